// File: rtl/unsigned_lt_compare_unit.sv
// Registered add/subtract and compare unit.
// The adder computes a+b or a-b. Its result is registered together with a zero
// flag and an unsigned a<b flag, so all outputs are valid one clock later.
// Optional build macro COMPARE_UNIT_SIGNED_LT_EN adds a registered signed
// less-than output lt_s.
// Requires WIDTH >= 2.

module unsigned_lt_compare_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_in,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             eq,
  output logic             lt_u,
`ifdef COMPARE_UNIT_SIGNED_LT_EN
  output logic             lt_s,
`endif
  output logic             valid_out
);

  localparam int unsigned Msb = WIDTH - 1;

  logic [WIDTH-1:0] b_op;
  logic [WIDTH:0]   sum_full;
  logic [WIDTH-1:0] sum_d;
  logic             cout_d;
  logic             eq_d;
  logic             lt_u_d;

  logic [WIDTH-1:0] s_q;
  logic             cout_q;
  logic             eq_q;
  logic             lt_u_q;
  logic             valid_q;

  // Shared adder: subtract is a + ~b + 1, so b is inverted and carry-in is sub.
  always_comb begin
    b_op     = b ^ {WIDTH{sub}};
    sum_full = {1'b0, a} + {1'b0, b_op} + {{WIDTH{1'b0}}, sub};
    sum_d    = sum_full[WIDTH-1:0];
    cout_d   = sum_full[WIDTH];
  end

  // Flags: in subtract mode a missing carry-out means a borrow, i.e. a < b.
  // Equal operands give cout=1, so the ~eq term is redundant but kept explicit.
  always_comb begin
    eq_d   = (sum_d == '0);
    lt_u_d = sub & ~cout_d & ~eq_d;
  end

`ifdef COMPARE_UNIT_SIGNED_LT_EN
  logic ovf_d;
  logic lt_s_d;
  logic lt_s_q;

  // Signed less-than: sign of the difference, corrected for signed overflow.
  always_comb begin
    ovf_d  = (a[Msb] != b[Msb]) & (sum_d[Msb] != a[Msb]);
    lt_s_d = sub & (sum_d[Msb] ^ ovf_d);
  end

  // Signed flag register follows the same reset/enable rules as the others.
  always_ff @(posedge clk) begin
    if (rst) begin
      lt_s_q <= 1'b0;
    end else if (valid_in) begin
      lt_s_q <= lt_s_d;
    end
  end

  assign lt_s = lt_s_q;
`endif

  // Result registers: reset wins over valid_in; results hold while valid_in=0.
  always_ff @(posedge clk) begin
    if (rst) begin
      s_q     <= '0;
      cout_q  <= 1'b0;
      eq_q    <= 1'b0;
      lt_u_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= valid_in;
      if (valid_in) begin
        s_q    <= sum_d;
        cout_q <= cout_d;
        eq_q   <= eq_d;
        lt_u_q <= lt_u_d;
      end
    end
  end

  assign s         = s_q;
  assign cout      = cout_q;
  assign eq        = eq_q;
  assign lt_u      = lt_u_q;
  assign valid_out = valid_q;

endmodule

// File: tb/tb_unsigned_lt_compare_unit.sv
// Scoreboard bench for unsigned_lt_compare_unit: each driven cycle pushes the
// expected register contents; a monitor pops and compares after every clock edge.

module tb_unsigned_lt_compare_unit;

  localparam int unsigned W = 32;

  logic         clk;
  logic         rst;
  logic         valid_in;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         sub;
  logic [W-1:0] s;
  logic         cout;
  logic         eq;
  logic         lt_u;
  logic         valid_out;
`ifdef COMPARE_UNIT_SIGNED_LT_EN
  logic         lt_s;
`endif

  typedef struct packed {
    logic [W-1:0] s;
    logic         cout;
    logic         eq;
    logic         lt_u;
    logic         lt_s;
    logic         vld;
  } exp_t;

  exp_t exp_q[$];
  exp_t held;
  int   errors = 0;
  int   checks = 0;

  unsigned_lt_compare_unit #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .valid_in (valid_in),
    .a        (a),
    .b        (b),
    .sub      (sub),
    .s        (s),
    .cout     (cout),
    .eq       (eq),
    .lt_u     (lt_u),
`ifdef COMPARE_UNIT_SIGNED_LT_EN
    .lt_s     (lt_s),
`endif
    .valid_out(valid_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, expv, $time);
    end
  endtask

  // Monitor: every captured cycle has one expected entry.
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("s", s, e.s);
      chk("cout", {31'b0, cout}, {31'b0, e.cout});
      chk("eq", {31'b0, eq}, {31'b0, e.eq});
      chk("lt_u", {31'b0, lt_u}, {31'b0, e.lt_u});
      chk("valid_out", {31'b0, valid_out}, {31'b0, e.vld});
`ifdef COMPARE_UNIT_SIGNED_LT_EN
      chk("lt_s", {31'b0, lt_s}, {31'b0, e.lt_s});
`endif
    end
  end

  // Drive one cycle with a hand-computed expectation.
  task automatic drive(input logic r, input logic v, input logic [W-1:0] av,
                       input logic [W-1:0] bv, input logic sb, input exp_t e);
    @(negedge clk);
    rst      = r;
    valid_in = v;
    a        = av;
    b        = bv;
    sub      = sb;
    exp_q.push_back(e);
    held = e;
  endtask

  // Drive one valid operation with the expectation from a reference model.
  task automatic drive_model(input logic [W-1:0] av, input logic [W-1:0] bv, input logic sb);
    exp_t e;
    logic [W:0] sum;
    if (sb) begin
      e.s    = av - bv;
      e.cout = (av >= bv);
      e.eq   = (av == bv);
      e.lt_u = (av < bv);
      e.lt_s = ($signed(av) < $signed(bv));
    end else begin
      sum    = {1'b0, av} + {1'b0, bv};
      e.s    = sum[W-1:0];
      e.cout = sum[W];
      e.eq   = (sum[W-1:0] == '0);
      e.lt_u = 1'b0;
      e.lt_s = 1'b0;
    end
    e.vld = 1'b1;
    drive(1'b0, 1'b1, av, bv, sb, e);
  endtask

  initial begin
    exp_t z;
    exp_t h;
    int   wait_cycles;
    z = '0;
    rst = 1'b1; valid_in = 1'b0; a = '0; b = '0; sub = 1'b0;

    // Reset with an operation presented: dropped.
    drive(1'b1, 1'b1, 32'd5, 32'd3, 1'b1, z);
    drive(1'b1, 1'b1, 32'd5, 32'd3, 1'b1, z);
    drive(1'b0, 1'b1, 32'd5, 32'd3, 1'b1, '{32'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1});

    // Equality and neighbours.
    drive(1'b0, 1'b1, 32'h7F, 32'h7F, 1'b1, '{32'h0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1});
    drive(1'b0, 1'b1, 32'h80, 32'h7F, 1'b1, '{32'h1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1});
    drive(1'b0, 1'b1, 32'h0, 32'h0, 1'b1, '{32'h0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1});

    // Extremes.
    drive(1'b0, 1'b1, 32'hFFFFFFFF, 32'h0, 1'b1,
          '{32'hFFFFFFFF, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1});
    drive(1'b0, 1'b1, 32'h0, 32'hFFFFFFFF, 1'b1, '{32'h1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1});
    drive(1'b0, 1'b1, 32'h0, 32'hFFFFFF00, 1'b1, '{32'h100, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1});

    // Add mode wrap, then hold with new operands.
    drive(1'b0, 1'b1, 32'hFFFFFFFF, 32'h1, 1'b0, '{32'h0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1});
    drive(1'b0, 1'b0, 32'h123, 32'h456, 1'b1, '{32'h0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0});
    drive(1'b0, 1'b0, 32'h0, 32'h1, 1'b1, '{32'h0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0});

    // Signed vs unsigned disagreement cases.
    drive(1'b0, 1'b1, 32'hFFFFFFFF, 32'h1, 1'b1,
          '{32'hFFFFFFFE, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1});
    drive(1'b0, 1'b1, 32'h7FFFFFFF, 32'h80000000, 1'b1,
          '{32'hFFFFFFFF, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1});

    // Add mode never reports less-than.
    drive(1'b0, 1'b1, 32'h1, 32'h2, 1'b0, '{32'h3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1});

    // Reset mid-stream with valid operands.
    drive(1'b1, 1'b1, 32'h1, 32'h2, 1'b1, z);

    // Subtract sweep: a small unsigned, b sign-extended from -256..255.
    for (int i = 0; i < 256; i += 15) begin
      for (int j = -256; j < 256; j += 7) begin
        logic [W-1:0] bv;
        bv = W'(j);
        drive_model(W'(i), bv, 1'b1);
      end
    end
    // Hold after sweep.
    h = held;
    h.vld = 1'b0;
    drive(1'b0, 1'b0, 32'hDEAD, 32'hBEEF, 1'b0, h);

    @(negedge clk);
    valid_in = 1'b0;
    wait_cycles = 0;
    while (exp_q.size() > 0 && wait_cycles < 10) begin
      @(negedge clk);
      wait_cycles++;
    end
    chk("drain", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/unsigned_lt_compare_unit.md
Name: unsigned_lt_compare_unit

Overview:
Registered 32-bit add/subtract and compare unit for the integer datapath.
- The adder computes A+B or A−B.
- An equality detector tests the result for zero.
- An unsigned less-than decoder derives A<B from the subtract carry-out and the zero flag.
- All results are registered once, so downstream branch/SLTU logic sees stable flags one clock after the operands are presented.

Parameters:
WIDTH, 32, operand and result width in bits (must be ≥2).

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous reset, active-high
valid_in  input  1  operands valid this cycle
a  input  WIDTH  operand A
b  input  WIDTH  operand B
sub  input  1  1 = subtract (A−B), 0 = add (A+B)
s  output  WIDTH  registered sum/difference
cout  output  1  registered adder carry-out
eq  output  1  registered zero flag of s
lt_u  output  1  registered unsigned A<B
valid_out  output  1  registered valid_in

Behaviour:
- Adder:
  - Subtract is A + ~B + 1: B is inverted and carry-in = sub.
  - s = low WIDTH bits of the result; cout = bit WIDTH of the full sum.
  - Wrap-around is silent and there is no overflow flag.
- eq = 1 iff all WIDTH bits of the adder result are 0; this holds in both modes.
- lt_u = sub & ~cout & ~eq.
  - In subtract mode cout=1 means A≥B unsigned; equal operands give cout=1, so lt_u=0.
  - lt_u is forced 0 when sub=0.
- Registers:
  - All outputs are captured on the rising clk edge when valid_in=1.
  - valid_out <= valid_in every cycle.
  - When valid_in=0, s/cout/eq/lt_u hold their previous values.
  - Latency is exactly 1 cycle; throughput is one operation per cycle; there is no stall or backpressure.
- Reset:
  - When rst=1 at a clk edge: s=0, cout=0, eq=0, lt_u=0, valid_out=0.
  - rst overrides valid_in in the same cycle; an operation presented during reset is dropped.
  - The first valid result appears the cycle after rst deasserts and valid_in=1.
- Boundaries:
  - A=B=0 in subtract mode gives s=0, cout=1, eq=1, lt_u=0.
  - A=0, B=all-ones gives lt_u=1.
  - A=all-ones, B=0 gives lt_u=0.
  - Operands are treated as unsigned throughout; the MSB has no sign meaning.

Optional Feature:
- Macro COMPARE_UNIT_SIGNED_LT_EN.
- When defined:
  - Adds output lt_s (1 bit, registered with the same enable/reset rules, reset value 0).
  - lt_s = sub & (d[WIDTH−1] XOR ovf), where d is the WIDTH-bit difference s and ovf is signed overflow: (a[MSB]≠b[MSB]) & (s[MSB]≠a[MSB]).
  - lt_s is 0 when sub=0.
- When undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Reset and hold: assert rst 2 cycles with valid_in=1, a=5, b=3 → all outputs 0 and valid_out=0. Release rst → next cycle s=2, cout=1, eq=0, lt_u=0.
- Unsigned sweep in subtract mode: i in 0..255, j in −256..255 sign-extended to 32 bits → lt_u equals (a<b unsigned) one cycle later with 0 mismatches. Example: a=0, b=0xFFFFFF00 → lt_u=1.
- Equality: a=b=0x0000007F, sub=1 → s=0, eq=1, cout=1, lt_u=0. Then a=0x80, b=0x7F → eq=0, lt_u=0.
- Extremes: a=0xFFFFFFFF, b=0, sub=1 → lt_u=0, cout=1. Then a=0, b=0xFFFFFFFF → lt_u=1, cout=0, s=1.
- Add mode and hold: a=0xFFFFFFFF, b=1, sub=0 → s=0, cout=1, eq=1, lt_u=0. Next cycle valid_in=0 with new operands → outputs unchanged, valid_out=0.
- Signed option (macro defined): a=0xFFFFFFFF, b=1, sub=1 → lt_s=1, lt_u=0. Then a=0x7FFFFFFF, b=0x80000000 → lt_s=0, lt_u=1.
